// File: rtl/regfile_irq_nest.sv
// regfile_irq_nest: general register bank with optional write-to-read bypass
// and syscall port override, plus a CP0 subset (IE, mask, EPC/level stack)
// for prioritised nested interrupts. Reads serve ID; writes and takes serve WB.
module regfile_irq_nest #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int NUM_IRQ = 4,
  parameter int STACK_D = 4,
  parameter int BYPASS  = 1,
  parameter int SYS_A   = 2,
  parameter int SYS_B   = 4,
  localparam int VEC_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  localparam int DEP_W  = $clog2(STACK_D + 1)
) (
  input  logic                     in_clk,
  input  logic                     in_RST,
  input  logic                     in_we,
  input  logic [ADDR_W-1:0]        in_waddr,
  input  logic [DATA_W-1:0]        in_wdata,
  input  logic [NUM_RD*ADDR_W-1:0] in_raddr,
  output logic [NUM_RD*DATA_W-1:0] out_rdata,
  input  logic                     in_syscall,
  input  logic                     in_cp_we,
  input  logic [1:0]               in_cp_sel,
  input  logic [DATA_W-1:0]        in_cp_wdata,
  output logic [DATA_W-1:0]        out_cp_rdata,
  input  logic [NUM_IRQ-1:0]       in_irq,
  input  logic                     in_retire_valid,
  input  logic [DATA_W-1:0]        in_pc,
  input  logic                     in_eret,
  output logic                     out_irq_take,
  output logic [VEC_W-1:0]         out_vector,
  output logic [DATA_W-1:0]        out_epc,
  output logic                     out_ie,
  output logic [NUM_IRQ-1:0]       out_mask,
  output logic [DEP_W-1:0]         out_depth
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LVL_W = $clog2(NUM_IRQ + 1);

  logic [DATA_W-1:0]  regs_q [DEPTH];
  logic [DATA_W-1:0]  regs_d [DEPTH];
  logic [DATA_W-1:0]  epc_q  [STACK_D];
  logic [DATA_W-1:0]  epc_d  [STACK_D];
  logic [LVL_W-1:0]   lvl_q  [STACK_D];
  logic [LVL_W-1:0]   lvl_d  [STACK_D];
  logic [DEP_W-1:0]   depth_q, depth_d;
  logic               ie_q, ie_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;

  logic [ADDR_W-1:0]  eff_raddr [NUM_RD];
  logic [DATA_W-1:0]  top_epc;
  logic [LVL_W-1:0]   cur_level;
  logic [NUM_IRQ-1:0] pending;
  logic [VEC_W-1:0]   cand;
  logic [LVL_W-1:0]   cand_level;
  logic               take;

  // Read ports: syscall redirects ports 0/1, register 0 is hardwired to zero,
  // and a same-cycle write to the addressed register is forwarded when enabled.
  always_comb begin
    out_rdata = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      eff_raddr[k] = in_raddr[k*ADDR_W +: ADDR_W];
      if (in_syscall && k == 0) eff_raddr[k] = ADDR_W'(SYS_A);
      if (in_syscall && k == 1) eff_raddr[k] = ADDR_W'(SYS_B);
      if (eff_raddr[k] != '0) out_rdata[k*DATA_W +: DATA_W] = regs_q[eff_raddr[k]];
      if (BYPASS != 0 && in_we && in_waddr != '0 && in_waddr == eff_raddr[k])
        out_rdata[k*DATA_W +: DATA_W] = in_wdata;
    end
  end

  // Top of the EPC/level stack; an empty stack presents EPC 0 and level 0.
  always_comb begin
    top_epc   = '0;
    cur_level = '0;
    for (int i = 0; i < STACK_D; i++) begin
      if (DEP_W'(i + 1) == depth_q) begin
        top_epc   = epc_q[i];
        cur_level = lvl_q[i];
      end
    end
  end

  // Highest-index unmasked request wins; its level is index+1 so 0 means idle.
  always_comb begin
    pending    = in_irq & mask_q;
    cand       = '0;
    cand_level = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (pending[i]) begin
        cand       = VEC_W'(i);
        cand_level = LVL_W'(i + 1);
      end
    end
    take = ie_q && (pending != '0) && in_retire_valid && (cand_level > cur_level) &&
           (depth_q < DEP_W'(STACK_D)) && !in_eret;
  end

  // Next state: register write, then stack pop/push (eret wins), then CP0
  // writes, where an EPC write targets whichever entry is top after the stack op.
  always_comb begin
    regs_d  = regs_q;
    epc_d   = epc_q;
    lvl_d   = lvl_q;
    depth_d = depth_q;
    ie_d    = ie_q;
    mask_d  = mask_q;
    if (in_we && in_waddr != '0) regs_d[in_waddr] = in_wdata;
    if (in_eret && depth_q != '0) begin
      depth_d = depth_q - DEP_W'(1);
    end else if (take) begin
      for (int i = 0; i < STACK_D; i++) begin
        if (DEP_W'(i) == depth_q) begin
          epc_d[i] = in_pc + DATA_W'(1);
          lvl_d[i] = cand_level;
        end
      end
      depth_d = depth_q + DEP_W'(1);
    end
    if (in_cp_we) begin
      case (in_cp_sel)
        2'd0: ie_d = in_cp_wdata[0];
        2'd1: mask_d = in_cp_wdata[NUM_IRQ-1:0];
        2'd2: begin
          for (int i = 0; i < STACK_D; i++)
            if (DEP_W'(i + 1) == depth_d) epc_d[i] = in_cp_wdata;
        end
        default: ;
      endcase
    end
  end

  // State registers, cleared immediately by reset even mid-handler.
  always_ff @(posedge in_clk or negedge in_RST) begin
    if (!in_RST) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      for (int i = 0; i < STACK_D; i++) begin
        epc_q[i] <= '0;
        lvl_q[i] <= '0;
      end
      depth_q <= '0;
      ie_q    <= 1'b0;
      mask_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      epc_q   <= epc_d;
      lvl_q   <= lvl_d;
      depth_q <= depth_d;
      ie_q    <= ie_d;
      mask_q  <= mask_d;
    end
  end

  // CP0 read mux and status outputs.
  always_comb begin
    case (in_cp_sel)
      2'd0:    out_cp_rdata = {{(DATA_W-1){1'b0}}, ie_q};
      2'd1:    out_cp_rdata = DATA_W'(mask_q);
      2'd2:    out_cp_rdata = top_epc;
      default: out_cp_rdata = '0;
    endcase
    out_irq_take = take;
    out_vector   = cand;
    out_epc      = top_epc;
    out_ie       = ie_q;
    out_mask     = mask_q;
    out_depth    = depth_q;
  end

endmodule

// File: tb/tb_regfile_irq_nest.sv
// tb_regfile_irq_nest: directed and random stimulus against a queue-based
// reference model of the register file and nested interrupt stack.
module tb_regfile_irq_nest;

  localparam int SD = 2;

  logic        in_clk = 1'b0;
  logic        in_RST, in_we, in_syscall, in_cp_we, in_retire_valid, in_eret;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata, in_cp_wdata, in_pc;
  logic [9:0]  in_raddr;
  logic [63:0] out_rdata;
  logic [1:0]  in_cp_sel;
  logic [31:0] out_cp_rdata, out_epc;
  logic [3:0]  in_irq, out_mask;
  logic        out_irq_take, out_ie;
  logic [1:0]  out_vector, out_depth;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_regs [32];
  logic        m_ie;
  logic [3:0]  m_mask;
  logic [31:0] m_epc [$];
  int          m_lvl [$];

  regfile_irq_nest #(.STACK_D(SD)) dut (
    .in_clk(in_clk), .in_RST(in_RST), .in_we(in_we), .in_waddr(in_waddr),
    .in_wdata(in_wdata), .in_raddr(in_raddr), .out_rdata(out_rdata),
    .in_syscall(in_syscall), .in_cp_we(in_cp_we), .in_cp_sel(in_cp_sel),
    .in_cp_wdata(in_cp_wdata), .out_cp_rdata(out_cp_rdata), .in_irq(in_irq),
    .in_retire_valid(in_retire_valid), .in_pc(in_pc), .in_eret(in_eret),
    .out_irq_take(out_irq_take), .out_vector(out_vector), .out_epc(out_epc),
    .out_ie(out_ie), .out_mask(out_mask), .out_depth(out_depth)
  );

  always #5 in_clk = ~in_clk;

  task automatic modelReset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_ie = 1'b0;
    m_mask = '0;
    m_epc.delete();
    m_lvl.delete();
  endtask

  function automatic logic [31:0] expRead(int k);
    int a;
    a = int'(in_raddr[k*5 +: 5]);
    if (in_syscall && k == 0) a = 2;
    if (in_syscall && k == 1) a = 4;
    if (in_we && in_waddr != 0 && int'(in_waddr) == a) return in_wdata;
    if (a == 0) return 32'd0;
    return m_regs[a];
  endfunction

  function automatic logic expTake(output int cand);
    int cur;
    cand = -1;
    for (int i = 0; i < 4; i++) if (in_irq[i] && m_mask[i]) cand = i;
    cur = (m_lvl.size() > 0) ? m_lvl[m_lvl.size()-1] : 0;
    return m_ie && cand >= 0 && in_retire_valid && (cand + 1 > cur) &&
           m_epc.size() < SD && !in_eret;
  endfunction

  task automatic modelEdge();
    int  cand;
    logic t;
    if (!in_RST) begin
      modelReset();
      return;
    end
    t = expTake(cand);
    if (in_we && in_waddr != 0) m_regs[in_waddr] = in_wdata;
    if (in_eret && m_epc.size() > 0) begin
      void'(m_epc.pop_back());
      void'(m_lvl.pop_back());
    end else if (t) begin
      m_epc.push_back(in_pc + 32'd1);
      m_lvl.push_back(cand + 1);
    end
    if (in_cp_we) begin
      case (in_cp_sel)
        2'd0: m_ie = in_cp_wdata[0];
        2'd1: m_mask = in_cp_wdata[3:0];
        2'd2: if (m_epc.size() > 0) m_epc[m_epc.size()-1] = in_cp_wdata;
        default: ;
      endcase
    end
  endtask

  task automatic checkOutput(string tag);
    logic [31:0] e_rd0, e_rd1, e_cp, e_epc;
    logic        e_take;
    int          cand;
    vectors++;
    e_rd0  = expRead(0);
    e_rd1  = expRead(1);
    e_take = expTake(cand);
    e_epc  = (m_epc.size() > 0) ? m_epc[m_epc.size()-1] : 32'd0;
    case (in_cp_sel)
      2'd0:    e_cp = {31'd0, m_ie};
      2'd1:    e_cp = {28'd0, m_mask};
      2'd2:    e_cp = e_epc;
      default: e_cp = 32'd0;
    endcase
    assert (out_rdata[31:0] === e_rd0) else begin
      miscompares++;
      $error("[TB] FAIL %s/rd0 observed=%h expected=%h", tag, out_rdata[31:0], e_rd0);
    end
    assert (out_rdata[63:32] === e_rd1) else begin
      miscompares++;
      $error("[TB] FAIL %s/rd1 observed=%h expected=%h", tag, out_rdata[63:32], e_rd1);
    end
    assert (out_cp_rdata === e_cp) else begin
      miscompares++;
      $error("[TB] FAIL %s/cp_rdata observed=%h expected=%h", tag, out_cp_rdata, e_cp);
    end
    assert (out_irq_take === e_take) else begin
      miscompares++;
      $error("[TB] FAIL %s/take observed=%b expected=%b", tag, out_irq_take, e_take);
    end
    if (e_take) begin
      assert (out_vector === 2'(cand)) else begin
        miscompares++;
        $error("[TB] FAIL %s/vector observed=%0d expected=%0d", tag, out_vector, cand);
      end
    end
    assert (out_epc === e_epc) else begin
      miscompares++;
      $error("[TB] FAIL %s/epc observed=%h expected=%h", tag, out_epc, e_epc);
    end
    assert (out_ie === m_ie) else begin
      miscompares++;
      $error("[TB] FAIL %s/ie observed=%b expected=%b", tag, out_ie, m_ie);
    end
    assert (out_mask === m_mask) else begin
      miscompares++;
      $error("[TB] FAIL %s/mask observed=%h expected=%h", tag, out_mask, m_mask);
    end
    assert (out_depth === 2'(m_epc.size())) else begin
      miscompares++;
      $error("[TB] FAIL %s/depth observed=%0d expected=%0d", tag, out_depth, m_epc.size());
    end
  endtask

  // Called just after a falling edge with inputs already driven: check the
  // combinational view, let the rising edge happen, advance the model.
  task automatic applyStimulus(string tag);
    #1;
    checkOutput(tag);
    @(posedge in_clk);
    modelEdge();
    @(negedge in_clk);
  endtask

  task automatic clearInputs();
    in_we = 0; in_waddr = 0; in_wdata = 0; in_raddr = 0; in_syscall = 0;
    in_cp_we = 0; in_cp_sel = 0; in_cp_wdata = 0; in_irq = 0;
    in_retire_valid = 0; in_pc = 0; in_eret = 0;
  endtask

  task automatic doTake(logic [3:0] irq, logic [31:0] pc, string tag);
    clearInputs(); in_irq = irq; in_retire_valid = 1; in_pc = pc; in_cp_sel = 2;
    applyStimulus(tag);
  endtask

  task automatic doEret(string tag);
    clearInputs(); in_eret = 1; in_cp_sel = 2;
    applyStimulus(tag);
  endtask

  initial begin
    clearInputs();
    in_RST = 0;
    modelReset();
    @(negedge in_clk);
    applyStimulus("reset");
    in_RST = 1;

    // register file: bypass, storage, r0 and syscall override
    clearInputs(); in_we = 1; in_waddr = 5; in_wdata = 32'hDEADBEEF; in_raddr = {5'd5, 5'd5};
    applyStimulus("wr_r5_bypass");
    clearInputs(); in_raddr = {5'd5, 5'd5};
    applyStimulus("rd_r5_storage");
    clearInputs(); in_we = 1; in_waddr = 0; in_wdata = 7; in_raddr = {5'd0, 5'd0};
    applyStimulus("wr_r0");
    clearInputs(); in_raddr = {5'd0, 5'd5};
    applyStimulus("rd_r0");
    clearInputs(); in_we = 1; in_waddr = 2; in_wdata = 32'h11;
    applyStimulus("wr_r2");
    clearInputs(); in_we = 1; in_waddr = 4; in_wdata = 32'h22;
    applyStimulus("wr_r4");
    clearInputs(); in_syscall = 1; in_raddr = {5'd9, 5'd3};
    applyStimulus("syscall");

    // CP0 setup and readback
    clearInputs(); in_cp_we = 1; in_cp_sel = 0; in_cp_wdata = 1;
    applyStimulus("cp_ie");
    clearInputs(); in_cp_we = 1; in_cp_sel = 1; in_cp_wdata = 32'hFFFF_FFFF;
    applyStimulus("cp_mask");
    clearInputs(); in_cp_sel = 0;
    applyStimulus("cp_rd_ie");

    // nesting, priority, eret and full stack
    doTake(4'b0010, 32'h40, "take_irq1");
    doTake(4'b1000, 32'h80, "take_irq3");
    doTake(4'b0001, 32'h90, "irq0_blocked");
    doEret("eret1");
    doEret("eret2");
    doEret("eret_empty");
    doTake(4'b0001, 32'h10, "take_irq0");
    doTake(4'b0100, 32'h20, "take_irq2");
    doTake(4'b1000, 32'h30, "full_irq3");
    clearInputs(); in_irq = 4'b1000; in_retire_valid = 1; in_pc = 32'h50; in_eret = 1; in_cp_sel = 2;
    applyStimulus("eret_vs_take");
    doTake(4'b0001, 32'h60, "equal_blocked");
    doEret("eret_lower");
    doTake(4'b0001, 32'h70, "retake_irq0");
    clearInputs(); in_cp_we = 1; in_cp_sel = 2; in_cp_wdata = 32'hCAFE;
    in_irq = 4'b0100; in_retire_valid = 1; in_pc = 32'h99;
    applyStimulus("take_and_epc_write");
    clearInputs(); in_cp_sel = 2;
    applyStimulus("epc_written");
    doEret("eret_a");
    doEret("eret_b");
    doTake(4'b0010, 32'hFFFF_FFFF, "pc_wrap");
    doTake(4'b1000, 32'h100, "take_before_reset");

    // asynchronous reset in the middle of the handler, between edges
    clearInputs(); in_irq = 4'b1111; in_retire_valid = 1; in_raddr = {5'd2, 5'd5}; in_cp_sel = 2;
    #2;
    in_RST = 0;
    modelReset();
    applyStimulus("async_reset");
    in_RST = 1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_we           = 1'($urandom_range(0, 1));
      in_waddr        = 5'($urandom_range(0, 7));
      in_wdata        = $urandom;
      in_raddr        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      in_syscall      = ($urandom_range(0, 7) == 0);
      in_cp_we        = ($urandom_range(0, 5) == 0);
      in_cp_sel       = 2'($urandom_range(0, 3));
      in_cp_wdata     = $urandom | ((n < 20) ? 32'h1 : 32'h0);
      in_irq          = 4'($urandom_range(0, 15));
      in_retire_valid = 1'($urandom_range(0, 1));
      in_pc           = $urandom;
      in_eret         = ($urandom_range(0, 4) == 0);
      applyStimulus("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_irq_nest.md
Name: regfile_irq_nest

Overview:
- Parametrised successor of the single-level register file and CP0 pair.
- Holds a general register bank with configurable width, depth and read-port count, optional write-to-read bypass, and syscall read-port override.
- Holds a CP0 subset: IE, interrupt mask, and an EPC/level stack for prioritised nested interrupts.
- Sits at ID (reads) and WB (writes and interrupt take) of the pipelined CPU.

Parameters:
- DATA_W, 32: register and PC width.
- ADDR_W, 5: register address width; depth = 2^ADDR_W.
- NUM_RD, 2: number of read ports.
- NUM_IRQ, 4: number of interrupt lines; index NUM_IRQ-1 is highest priority.
- STACK_D, 4: EPC stack depth, i.e. maximum nesting (at least 1).
- BYPASS, 1: 1 = a same-cycle write is visible on the reads.
- SYS_A, 2: register forced onto read port 0 during syscall.
- SYS_B, 4: register forced onto read port 1 during syscall.

Ports:
- in_clk  in  1  clock, rising edge.
- in_RST  in  1  reset, asynchronous, active-low.
- in_we  in  1  register write enable.
- in_waddr  in  ADDR_W  write address.
- in_wdata  in  DATA_W  write data.
- in_raddr  in  NUM_RD*ADDR_W  read addresses; port k uses slice k.
- out_rdata  out  NUM_RD*DATA_W  read data; port k uses slice k.
- in_syscall  in  1  force ports 0 and 1 to SYS_A and SYS_B.
- in_cp_we  in  1  CP0 write enable.
- in_cp_sel  in  2  0 = status (bit0 IE), 1 = mask, 2 = top EPC, 3 = reserved.
- in_cp_wdata  in  DATA_W  CP0 write data.
- out_cp_rdata  out  DATA_W  CP0 read data for in_cp_sel; sel 3 reads 0.
- in_irq  in  NUM_IRQ  level interrupt requests.
- in_retire_valid  in  1  WB retires an instruction this cycle.
- in_pc  in  DATA_W  PC of the retiring instruction.
- in_eret  in  1  return from handler (WB).
- out_irq_take  out  1  interrupt accepted this cycle (combinational); pipeline flushes.
- out_vector  out  $clog2(NUM_IRQ)  index of the accepted line.
- out_epc  out  DATA_W  top-of-stack EPC; 0 when empty.
- out_ie  out  1  global interrupt enable.
- out_mask  out  NUM_IRQ  interrupt mask.
- out_depth  out  $clog2(STACK_D+1)  current nesting depth.

Behaviour:
- Reset (in_RST=0, immediate, also mid-handler):
  - all registers = 0, IE = 0, mask = 0, stack emptied, depth = 0, level = 0.
  - out_irq_take = 0, out_epc = 0.
- Register write:
  - On the rising edge when in_we=1 and in_waddr != 0.
  - Register 0 always reads 0; writes to it are dropped.
- Reads are combinational.
  - in_syscall=1 overrides the port 0 and port 1 addresses with SYS_A and SYS_B; other ports are unaffected.
  - BYPASS=1: if in_we=1, in_waddr != 0 and in_waddr equals the effective read address, the read returns in_wdata.
  - BYPASS=0: the read returns the old value until after the edge.
- Pending = in_irq & mask.
  - cand = highest set index of pending; cand_level = cand+1.
  - Current level = level stored at stack top; 0 if the stack is empty.
- Take condition: IE=1, pending != 0, in_retire_valid=1, cand_level > current level, depth < STACK_D, in_eret=0.
  - When the condition holds: out_irq_take=1 and out_vector=cand in the same cycle.
  - At the edge: push {in_pc+1, cand_level}, depth += 1.
- Eret with depth > 0: pop at the edge, depth -= 1; the restored level is the new top.
  - Eret with depth = 0 is ignored.
  - Eret has priority over a take in the same cycle.
  - A line may be re-taken in the next cycle.
- Stack full (depth = STACK_D): takes are blocked regardless of priority; IE is unchanged.
- Equal or lower priority than the current level never preempts.
  - It stays pending and is taken after the eret that lowers the level.
- CP0 write applies at the edge.
  - sel 2 overwrites the top EPC only; with an empty stack it is a no-op.
  - Same-cycle CP0 write and take/eret: the stack operation happens first, then the sel 2 write lands on the new top.
- Width rules:
  - in_pc+1 wraps modulo 2^DATA_W.
  - Mask writes use in_cp_wdata[NUM_IRQ-1:0].

Test Plan:
- Write 0xDEADBEEF to r5, read r5 on both ports -> same-cycle value 0xDEADBEEF with BYPASS=1; the next cycle reads it from storage. Write r0 = 7 -> reads 0.
- in_syscall=1 with r2 = 0x11 and r4 = 0x22, raddr = {9, 3} -> out_rdata ports 0/1 = 0x11/0x22.
- IE=1, mask=0xF, irq[1] with retire at pc 0x40 -> take, vector 1, epc 0x41, depth 1. Then irq[3] at pc 0x80 -> take, depth 2, epc 0x81. Then irq[0] -> no take.
- Eret twice -> epc 0x41, then 0; depth back to 0. Third eret -> ignored.
- STACK_D=2 at full depth, then irq[3] -> no take. irq and eret in the same cycle -> pop only, no take.
- in_RST low mid-handler at depth 2 -> all outputs 0 immediately, before the next clock edge.
